// File: rtl/z_mac_pkg.sv
// Shared types and helpers for the z MAC writer: FSM state encoding and
// a counter-width helper.
package z_mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        ADD   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        if (n > 32'sd1) begin
            return $clog2(n);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/z_sat.sv
// Output formatter: arithmetic shift right by FRAC_BITS (floor), then reduce
// the accumulator to a D_WIDTH z word.
// Optional macro Z_MAC_SAT_EN: when defined the value saturates to the signed
// D_WIDTH range, otherwise the low D_WIDTH bits are kept (two's-complement wrap).
module z_sat #(
    parameter int ACC_WIDTH = 12,
    parameter int D_WIDTH   = 4,
    parameter int FRAC_BITS = 2
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [D_WIDTH-1:0]   z
);

    logic [ACC_WIDTH-1:0] shifted_s;

    assign shifted_s = $signed(acc) >>> FRAC_BITS;

`ifdef Z_MAC_SAT_EN
    // Bits above the z sign bit must all match the sign for the value to fit.
    logic [ACC_WIDTH-D_WIDTH:0] upper_s;

    assign upper_s = shifted_s[ACC_WIDTH-1:D_WIDTH-1];

    // Clamp to the most positive / most negative z word on overflow.
    always_comb begin
        z = shifted_s[D_WIDTH-1:0];
        if ((~|upper_s) || (&upper_s)) begin
            z = shifted_s[D_WIDTH-1:0];
        end else if (shifted_s[ACC_WIDTH-1]) begin
            z = {1'b1, {(D_WIDTH-1){1'b0}}};
        end else begin
            z = {1'b0, {(D_WIDTH-1){1'b1}}};
        end
    end
`else
    // High bits are intentionally discarded in wrap mode.
    logic unused_hi_s;

    assign unused_hi_s = ^shifted_s[ACC_WIDTH-1:D_WIDTH];

    // Wrap: keep the low D_WIDTH bits of the shifted value.
    always_comb begin
        z = shifted_s[D_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/z_mac_writer.sv
// z MAC writer: accumulates N_IN act*wgt products plus a bias per neuron and
// writes the formatted pre-activation into the z RAM, for N_OUT neurons.
// Optional macro Z_MAC_SAT_EN selects saturating output formatting (see z_sat).
module z_mac_writer
    import z_mac_pkg::*;
#(
    parameter int D_WIDTH   = 4,
    parameter int A_WIDTH   = 4,
    parameter int N_IN      = 4,
    parameter int N_OUT     = 16,
    parameter int FRAC_BITS = 2,
    parameter int ACC_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_act,
    input  logic [D_WIDTH-1:0] in_wgt,
    output logic [A_WIDTH-1:0] b_addr,
    input  logic [D_WIDTH-1:0] b_data,
    output logic               w_en,
    output logic [A_WIDTH-1:0] w_addr,
    output logic [D_WIDTH-1:0] w_data,
    output logic               busy,
    output logic               done
);

    localparam int TERM_W = cnt_width(N_IN);
    localparam logic [TERM_W-1:0]  TERM_LAST_C   = TERM_W'(N_IN - 1);
    localparam logic [A_WIDTH-1:0] NEURON_LAST_C = A_WIDTH'(N_OUT - 1);

    state_e               state_r, state_nxt_s;
    logic [ACC_WIDTH-1:0] acc_r, acc_nxt_s;
    logic [TERM_W-1:0]    term_cnt_r, term_nxt_s;
    logic [A_WIDTH-1:0]   neuron_cnt_r, neuron_nxt_s;
    logic                 in_ready_r, in_ready_nxt_s;
    logic                 w_en_r, w_en_nxt_s;
    logic [A_WIDTH-1:0]   w_addr_r, w_addr_nxt_s;
    logic [D_WIDTH-1:0]   w_data_r, w_data_nxt_s;
    logic [A_WIDTH-1:0]   b_addr_r;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;

    logic signed [2*D_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]        prod_ext_s;
    logic [ACC_WIDTH-1:0]        bias_ext_s;
    logic [ACC_WIDTH-1:0]        acc_sum_s;
    logic [D_WIDTH-1:0]          z_s;

    assign prod_s     = $signed(in_act) * $signed(in_wgt);
    assign prod_ext_s = {{(ACC_WIDTH-2*D_WIDTH){prod_s[2*D_WIDTH-1]}}, prod_s};
    // Bias is aligned to the product scale (2*FRAC_BITS fractional bits).
    assign bias_ext_s = {{(ACC_WIDTH-D_WIDTH-FRAC_BITS){b_data[D_WIDTH-1]}},
                         b_data, {FRAC_BITS{1'b0}}};
    assign acc_sum_s  = acc_r + bias_ext_s;

    z_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .D_WIDTH   (D_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_z_sat (
        .acc (acc_sum_s),
        .z   (z_s)
    );

    // Next-state and next-output logic; w_data is captured in ADD so the
    // write is presented, registered, during the WRITE cycle.
    always_comb begin
        state_nxt_s    = state_r;
        acc_nxt_s      = acc_r;
        term_nxt_s     = term_cnt_r;
        neuron_nxt_s   = neuron_cnt_r;
        in_ready_nxt_s = 1'b0;
        w_en_nxt_s     = 1'b0;
        w_addr_nxt_s   = w_addr_r;
        w_data_nxt_s   = w_data_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s    = ACCUM;
                    acc_nxt_s      = {ACC_WIDTH{1'b0}};
                    term_nxt_s     = {TERM_W{1'b0}};
                    neuron_nxt_s   = {A_WIDTH{1'b0}};
                    in_ready_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            ACCUM: begin
                in_ready_nxt_s = 1'b1;
                if (in_valid && in_ready_r) begin
                    acc_nxt_s = acc_r + prod_ext_s;
                    if (term_cnt_r == TERM_LAST_C) begin
                        term_nxt_s     = {TERM_W{1'b0}};
                        in_ready_nxt_s = 1'b0;
                        state_nxt_s    = ADD;
                    end else begin
                        term_nxt_s     = term_cnt_r + {{(TERM_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            ADD: begin
                acc_nxt_s    = acc_sum_s;
                w_en_nxt_s   = 1'b1;
                w_addr_nxt_s = neuron_cnt_r;
                w_data_nxt_s = z_s;
                state_nxt_s  = WRITE;
            end
            WRITE: begin
                if (neuron_cnt_r == NEURON_LAST_C) begin
                    done_nxt_s     = 1'b1;
                    state_nxt_s    = DONE;
                end else begin
                    neuron_nxt_s   = neuron_cnt_r + {{(A_WIDTH-1){1'b0}}, 1'b1};
                    acc_nxt_s      = {ACC_WIDTH{1'b0}};
                    term_nxt_s     = {TERM_W{1'b0}};
                    in_ready_nxt_s = 1'b1;
                    state_nxt_s    = ACCUM;
                end
            end
            DONE: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= {ACC_WIDTH{1'b0}};
            term_cnt_r   <= {TERM_W{1'b0}};
            neuron_cnt_r <= {A_WIDTH{1'b0}};
            in_ready_r   <= 1'b0;
            w_en_r       <= 1'b0;
            w_addr_r     <= {A_WIDTH{1'b0}};
            w_data_r     <= {D_WIDTH{1'b0}};
            b_addr_r     <= {A_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            acc_r        <= acc_nxt_s;
            term_cnt_r   <= term_nxt_s;
            neuron_cnt_r <= neuron_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
            w_en_r       <= w_en_nxt_s;
            w_addr_r     <= w_addr_nxt_s;
            w_data_r     <= w_data_nxt_s;
            b_addr_r     <= neuron_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign in_ready = in_ready_r;
    assign w_en     = w_en_r;
    assign w_addr   = w_addr_r;
    assign w_data   = w_data_r;
    assign b_addr   = b_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_z_mac_writer.sv
// Self-checking bench for z_mac_writer (D_WIDTH=4, FRAC_BITS=2, N_IN=2,
// N_OUT=2, ACC_WIDTH=12). Expectations follow Z_MAC_SAT_EN when defined.
module tb_z_mac_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_act;
    logic [3:0] in_wgt;
    logic [3:0] b_addr;
    logic [3:0] b_data;
    logic       w_en;
    logic [3:0] w_addr;
    logic [3:0] w_data;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic signed [3:0] a0, w0, a1, w1, bias;
        logic [3:0]        exp_z;
    } vec_t;

    vec_t       tbl [8];
    logic [3:0] bias_rom [16];
    logic [3:0] cap_addr [64];
    logic [3:0] cap_data [64];
    int         wr_n   = 0;
    int         done_n = 0;

    z_mac_writer #(
        .D_WIDTH(4), .A_WIDTH(4), .N_IN(2), .N_OUT(2), .FRAC_BITS(2), .ACC_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .b_addr(b_addr), .b_data(b_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered-address bias ROM: data follows the address one cycle later.
    always @(posedge clk) b_data <= bias_rom[b_addr];

    // Record every z RAM write and done pulse.
    always @(negedge clk) begin
        if (w_en && wr_n < 64) begin
            cap_addr[wr_n] = w_addr;
            cap_data[wr_n] = w_data;
            wr_n++;
        end
        if (done) done_n++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_w_en"},     int'(w_en),     0);
        check({tag, "_w_addr"},   int'(w_addr),   0);
        check({tag, "_w_data"},   int'(w_data),   0);
        check({tag, "_b_addr"},   int'(b_addr),   0);
        check({tag, "_busy"},     int'(busy),     0);
        check({tag, "_done"},     int'(done),     0);
    endtask

    // Present one pair from a negedge until it is accepted (bounded).
    task automatic send_beat(input logic [3:0] act, input logic [3:0] wgt, input bit pulse);
        bit ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            in_valid = 1'b1;
            in_act   = act;
            in_wgt   = wgt;
            start    = pulse && (c == 0);
            ok       = in_ready;
            @(negedge clk);
            start    = 1'b0;
        end
        check("beat_accept", int'(ok), 1);
    endtask

    // One full layer using table rows base and base+1.
    task automatic run_layer(input int base, input bit gaps, input bit restart);
        int  w0 = wr_n;
        int  d0 = done_n;
        bit  seen = 1'b0;
        bias_rom[0] = tbl[base].bias;
        bias_rom[1] = tbl[base+1].bias;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int n = 0; n < 2; n++) begin
            send_beat(tbl[base+n].a0, tbl[base+n].w0, restart && (n == 1));
            if (gaps) begin
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            send_beat(tbl[base+n].a1, tbl[base+n].w1, 1'b0);
            // Offer a junk pair during ADD and WRITE; it must not be taken.
            in_valid = 1'b1;
            in_act   = 4'd7;
            in_wgt   = 4'd7;
            check("in_ready_add", int'(in_ready), 0);
            @(negedge clk);
            check("in_ready_write", int'(in_ready), 0);
            check("w_en_write", int'(w_en), 1);
            @(negedge clk);
            in_valid = 1'b0;
        end
        if (done) seen = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        check("busy_in_done", int'(busy), 1);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("in_ready_idle", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        check("write_count", wr_n - w0, 2);
        check("done_count", done_n - d0, 1);
        for (int n = 0; n < 2; n++) begin
            check($sformatf("addr_row%0d", base + n), int'(cap_addr[w0+n]), n);
            check($sformatf("data_row%0d", base + n), int'(cap_data[w0+n]),
                  int'(tbl[base+n].exp_z));
        end
    endtask

    initial begin
        int w0;
        int d0;
        // act0 wgt0 act1 wgt1 bias expected
        tbl[0] = '{a0: 4'sd2,  w0: 4'sd3, a1: 4'sd1,  w1: -4'sd2, bias: 4'sd1,  exp_z: 4'b0010};
        tbl[1] = '{a0: 4'sd0,  w0: 4'sd0, a1: 4'sd0,  w1: 4'sd0,  bias: 4'sd0,  exp_z: 4'b0000};
`ifdef Z_MAC_SAT_EN
        tbl[2] = '{a0: 4'sd7,  w0: 4'sd7, a1: 4'sd7,  w1: 4'sd7,  bias: 4'sd0,  exp_z: 4'b0111};
        tbl[3] = '{a0: -4'sd8, w0: 4'sd7, a1: -4'sd8, w1: 4'sd7,  bias: 4'sd0,  exp_z: 4'b1000};
`else
        tbl[2] = '{a0: 4'sd7,  w0: 4'sd7, a1: 4'sd7,  w1: 4'sd7,  bias: 4'sd0,  exp_z: 4'b1000};
        tbl[3] = '{a0: -4'sd8, w0: 4'sd7, a1: -4'sd8, w1: 4'sd7,  bias: 4'sd0,  exp_z: 4'b0100};
`endif
        // -1 >>> 2 floors to -1; (-3-4) = -7 >>> 2 floors to -2
        tbl[4] = '{a0: -4'sd1, w0: 4'sd1,  a1: 4'sd0, w1: 4'sd0, bias: 4'sd0,  exp_z: 4'b1111};
        tbl[5] = '{a0: 4'sd3,  w0: -4'sd1, a1: 4'sd0, w1: 4'sd0, bias: -4'sd1, exp_z: 4'b1110};
        // 9+1+8 = 18 -> 4;  -15+4-12 = -23 -> -6
        tbl[6] = '{a0: -4'sd3, w0: -4'sd3, a1: 4'sd1, w1: 4'sd1, bias: 4'sd2,  exp_z: 4'b0100};
        tbl[7] = '{a0: 4'sd5,  w0: -4'sd3, a1: 4'sd2, w1: 4'sd2, bias: -4'sd3, exp_z: 4'b1010};
        for (int i = 0; i < 16; i++) bias_rom[i] = 4'd0;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_act   = 4'd0;
        in_wgt   = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_layer(0, 1'b0, 1'b0);   // basic
        run_layer(2, 1'b0, 1'b0);   // positive / negative overflow
        run_layer(4, 1'b0, 1'b0);   // floor on negative values
        run_layer(6, 1'b1, 1'b0);   // backpressure gaps
        run_layer(0, 1'b1, 1'b0);   // basic with backpressure
        run_layer(0, 1'b0, 1'b1);   // start pulsed while busy

        // Reset in the cycle after the first accepted beat.
        w0 = wr_n;
        d0 = done_n;
        bias_rom[0] = tbl[0].bias;
        bias_rom[1] = tbl[1].bias;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_beat(tbl[0].a0, tbl[0].w0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_act   = tbl[0].a1;
        in_wgt   = tbl[0].w1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("midrst");
        repeat (10) @(negedge clk);
        check("midrst_no_write", wr_n - w0, 0);
        check("midrst_no_done", done_n - d0, 0);
        check("midrst_idle_busy", int'(busy), 0);
        run_layer(0, 1'b0, 1'b0);   // basic again after reset

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
